// File: rtl/alu_exec_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Multi-cycle integer execute unit for the EX stage. Takes one op (4-bit
//   alu_control code plus two operands) over a valid/ready handshake. It
//   returns the result, a zero flag and an illegal-code flag over a second
//   valid/ready handshake. By default shifts run serially, one bit per cycle.
//   Every other op completes in a single cycle.
//
//   Build option: define FAST_SHIFT_EN to replace the serial shifter with a
//   barrel shifter. Shifts then complete in one cycle. The SHIFT state and
//   the shift counter are not built. Results are identical in both builds.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   flush        synchronous abort of any in-flight op (overrides an accept)
//   in_valid     op request valid
//   in_ready     unit can accept an op (IDLE only)
//   in_ctrl      alu_control code
//   in_a, in_b   operands; shift amount = in_b[SHAMT_W-1:0]
//   out_valid    result valid; held until out_ready
//   out_ready    downstream accepts result
//   out_result   result
//   out_zero     out_result == 0, qualified by out_valid
//   out_illegal  in_ctrl was undefined, qualified by out_valid
//   busy         unit is not IDLE
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_ctrl,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_illegal,
  output logic            busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifndef FAST_SHIFT_EN
    S_SHIFT = 2'd1,
`endif
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   result_q;
  logic              illegal_q;

  // Single-cycle evaluation. Returns {illegal, result}. In the serial build
  // this is only reached by a shift when shamt==0, so a shift returns in_a.
  function automatic logic [XLEN:0] alu_eval(input logic [3:0]      c,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic            ill;
    r   = '0;
    ill = 1'b0;
    case (c)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef FAST_SHIFT_EN
      OP_SLL:  r = a << b[SHAMT_W-1:0];
      OP_SRL:  r = a >> b[SHAMT_W-1:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
`else
      OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

`ifndef FAST_SHIFT_EN
  logic [3:0]         ctrl_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] shamt_in;
  logic               start_serial;

  assign shamt_in     = in_b[SHAMT_W-1:0];
  assign start_serial = (in_ctrl == OP_SLL || in_ctrl == OP_SRL || in_ctrl == OP_SRA)
                        && (shamt_in != '0);

  // One-bit shift step for the serial shifter.
  function automatic logic [XLEN-1:0] shift_step(input logic [3:0]      c,
                                                 input logic [XLEN-1:0] v);
    case (c)
      OP_SLL:  return {v[XLEN-2:0], 1'b0};
      OP_SRA:  return {v[XLEN-1], v[XLEN-1:1]};
      default: return {1'b0, v[XLEN-1:1]};
    endcase
  endfunction
`endif

  // State register
  // NOTE: all clocked state uses non-blocking assignments so that every
  // always_ff block reads the pre-edge values, whatever order the blocks
  // are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  // NOTE: state_d takes a default before the case statement. Every path then
  // assigns it, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifndef FAST_SHIFT_EN
          if (start_serial) state_d = S_SHIFT;
          else
`endif
          state_d = S_DONE;
        end
      end
`ifndef FAST_SHIFT_EN
      S_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
`endif
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A flush aborts the in-flight op. It also wins over a same-cycle accept.
    if (flush) state_d = S_IDLE;
  end

  // Datapath registers. They are reset because out_result is architecturally
  // visible and must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifndef FAST_SHIFT_EN
      ctrl_q    <= '0;
      cnt_q     <= '0;
`endif
    end else if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
`ifndef FAST_SHIFT_EN
            ctrl_q <= in_ctrl;
            if (start_serial) begin
              result_q  <= in_a;
              illegal_q <= 1'b0;
              cnt_q     <= shamt_in;
            end else
`endif
            begin
              {illegal_q, result_q} <= alu_eval(in_ctrl, in_a, in_b);
            end
          end
        end
`ifndef FAST_SHIFT_EN
        S_SHIFT: begin
          result_q <= shift_step(ctrl_q, result_q);
          cnt_q    <= cnt_q - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready    = (state_q == S_IDLE);
    out_valid   = (state_q == S_DONE);
    busy        = (state_q != S_IDLE);
    out_result  = result_q;
    out_zero    = (state_q == S_DONE) && (result_q == '0);
    out_illegal = (state_q == S_DONE) && illegal_q;
  end

endmodule
